// File: rtl/mc_ctrl_fsm_pkg.sv
// mc_ctrl_fsm_pkg: opcode/funct constants, state codes, ALU_op codes, mux selects and instruction class indices.
package mc_ctrl_fsm_pkg;

    localparam logic [4:0] RA_IDX  = 5'd31;
    localparam int         STATE_W = 4;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_JAL = 6'b000011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_ORI = 6'b001101;
    localparam logic [5:0] OP_LUI = 6'b001111;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH, S_DECODE, S_EXE_R, S_EXE_I, S_MEM_ADR, S_MEM_RD, S_MEM_WR,
        S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP, S_JAL, S_JR
    } state_t;

    localparam logic [2:0] F_FUNCT = 3'b000;
    localparam logic [2:0] F_ADD   = 3'b001;
    localparam logic [2:0] F_SUB   = 3'b010;
    localparam logic [2:0] F_OR    = 3'b011;
    localparam logic [2:0] F_LUI   = 3'b100;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_4    = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_IMM2 = 2'b11;

    localparam logic [1:0] RD_RT = 2'b00;
    localparam logic [1:0] RD_RD = 2'b01;
    localparam logic [1:0] RD_RA = 2'b10;

    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MDR = 2'b01;
    localparam logic [1:0] M2R_PC  = 2'b10;

    localparam logic [1:0] PCS_ALU  = 2'b00;
    localparam logic [1:0] PCS_OUT  = 2'b01;
    localparam logic [1:0] PCS_JTGT = 2'b10;
    localparam logic [1:0] PCS_REGA = 2'b11;

    localparam int CL_R   = 0;
    localparam int CL_JR  = 1;
    localparam int CL_NOP = 2;
    localparam int CL_IMM = 3;
    localparam int CL_LW  = 4;
    localparam int CL_SW  = 5;
    localparam int CL_BEQ = 6;
    localparam int CL_J   = 7;
    localparam int CL_JAL = 8;
    localparam int CL_W   = 9;

endpackage

// File: rtl/mc_ctrl_fsm_class.sv
// mc_instr_class: maps opcode/funct to a one-hot instruction class; anything unrecognised is NOP.
module mc_instr_class
    import mc_ctrl_fsm_pkg::*;
(
    input  logic [5:0]      opcode_i,
    input  logic [5:0]      funct_i,
    output logic [CL_W-1:0] cls_o
);
    logic r_op;
    always_comb begin
        cls_o = '0;
        r_op = opcode_i == OP_R;
        cls_o[CL_R]   = r_op && (funct_i == FN_ADD || funct_i == FN_SUB);
        cls_o[CL_JR]  = r_op && funct_i == FN_JR;
        cls_o[CL_IMM] = opcode_i == OP_ORI || opcode_i == OP_LUI;
        cls_o[CL_LW]  = opcode_i == OP_LW;
        cls_o[CL_SW]  = opcode_i == OP_SW;
        cls_o[CL_BEQ] = opcode_i == OP_BEQ;
        cls_o[CL_J]   = opcode_i == OP_J;
        cls_o[CL_JAL] = opcode_i == OP_JAL;
        cls_o[CL_NOP] = ~|{cls_o[CL_R], cls_o[CL_JR], cls_o[CL_IMM], cls_o[CL_LW], cls_o[CL_SW],
                           cls_o[CL_BEQ], cls_o[CL_J], cls_o[CL_JAL]};
    end
endmodule

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle main controller sequencing PC, IR, ALU, register file and memory.
module mc_ctrl_fsm
    import mc_ctrl_fsm_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               zero,
    output logic               pc_we,
    output logic               ir_we,
    output logic               mem_we,
    output logic               rf_we,
    output logic [2:0]         ALU_op,
    output logic               alusrc_a,
    output logic [1:0]         alusrc_b,
    output logic               ext_op,
    output logic [1:0]         reg_dst,
    output logic [1:0]         mem_to_reg,
    output logic [1:0]         pc_src,
    output logic               instr_done,
    output logic [STATE_W-1:0] dbg_state
);
    state_t          state_q, state_d, s;
    logic [CL_W-1:0] cls;

    mc_instr_class u_class (.opcode_i(opcode), .funct_i(funct), .cls_o(cls));

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:   state_d = S_DECODE;
            S_DECODE:  state_d = cls[CL_R] ? S_EXE_R : cls[CL_JR] ? S_JR : cls[CL_IMM] ? S_EXE_I :
                                 (cls[CL_LW] | cls[CL_SW]) ? S_MEM_ADR : cls[CL_BEQ] ? S_BRANCH :
                                 cls[CL_J] ? S_JUMP : cls[CL_JAL] ? S_JAL : S_FETCH;
            S_EXE_R:   state_d = S_WB_R;
            S_EXE_I:   state_d = S_WB_I;
            S_MEM_ADR: state_d = cls[CL_LW] ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:  state_d = S_WB_MEM;
            default:   state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) state_q <= reset ? S_FETCH : state_d;

    // Reset presents FETCH's mux settings with every write enable suppressed.
    always_comb begin
        s = reset ? S_FETCH : state_q;
        pc_we = 1'b0;
        ir_we = 1'b0;
        mem_we = 1'b0;
        rf_we = 1'b0;
        ALU_op = F_ADD;
        alusrc_a = 1'b0;
        alusrc_b = SRCB_REG;
        ext_op = 1'b0;
        reg_dst = RD_RT;
        mem_to_reg = M2R_ALU;
        pc_src = PCS_ALU;
        instr_done = 1'b0;
        case (s)
            S_FETCH:   begin ir_we = 1'b1; pc_we = 1'b1; alusrc_b = SRCB_4; end
            S_DECODE:  begin alusrc_b = SRCB_IMM2; ext_op = 1'b1; instr_done = cls[CL_NOP]; end
            S_EXE_R:   begin alusrc_a = 1'b1; ALU_op = F_FUNCT; end
            S_WB_R:    begin rf_we = 1'b1; reg_dst = RD_RD; instr_done = 1'b1; end
            S_EXE_I:   begin alusrc_a = 1'b1; alusrc_b = SRCB_IMM; ALU_op = opcode == OP_LUI ? F_LUI : F_OR; end
            S_WB_I:    begin rf_we = 1'b1; instr_done = 1'b1; end
            S_MEM_ADR: begin alusrc_a = 1'b1; alusrc_b = SRCB_IMM; ext_op = 1'b1; end
            S_WB_MEM:  begin rf_we = 1'b1; mem_to_reg = M2R_MDR; instr_done = 1'b1; end
            S_MEM_WR:  begin mem_we = 1'b1; instr_done = 1'b1; end
            S_BRANCH:  begin alusrc_a = 1'b1; ALU_op = F_SUB; pc_src = PCS_OUT; pc_we = zero; instr_done = 1'b1; end
            S_JUMP:    begin pc_src = PCS_JTGT; pc_we = 1'b1; instr_done = 1'b1; end
            S_JAL:     begin pc_src = PCS_JTGT; pc_we = 1'b1; rf_we = 1'b1; reg_dst = RD_RA; mem_to_reg = M2R_PC; instr_done = 1'b1; end
            S_JR:      begin pc_src = PCS_REGA; pc_we = 1'b1; instr_done = 1'b1; end
            default:   ;
        endcase
        if (reset) {pc_we, ir_we, mem_we, rf_we, instr_done} = '0;
    end

    assign dbg_state = state_q;
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: random instruction stream checked each cycle against per-instruction expected output sequences.
module tb_mc_ctrl_fsm;
    import mc_ctrl_fsm_pkg::*;

    logic clk = 1'b0, reset = 1'b1, zero = 1'b0;
    logic [5:0] opcode = '0, funct = '0;
    logic pc_we, ir_we, mem_we, rf_we, alusrc_a, ext_op, instr_done;
    logic [2:0] ALU_op;
    logic [1:0] alusrc_b, reg_dst, mem_to_reg, pc_src;
    logic [3:0] dbg_state;

    always #5 clk = ~clk;

    mc_ctrl_fsm dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .pc_we(pc_we), .ir_we(ir_we), .mem_we(mem_we), .rf_we(rf_we), .ALU_op(ALU_op),
        .alusrc_a(alusrc_a), .alusrc_b(alusrc_b), .ext_op(ext_op), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .pc_src(pc_src), .instr_done(instr_done), .dbg_state(dbg_state)
    );

    typedef struct packed {
        logic [3:0]  st;
        logic [17:0] o;
        logic        br;
    } exp_t;

    exp_t q[$];
    int checks = 0, errors = 0;
    string names[13] = '{"add", "sub", "jr", "nop", "rfunk", "ori", "lui", "lw", "sw", "beq", "j", "jal", "unkop"};
    int lat[13] = '{4, 4, 3, 2, 2, 4, 4, 5, 4, 3, 3, 3, 2};
    int dir[9] = '{0, 7, 8, 9, 9, 11, 2, 12, 7};

    function automatic logic [17:0] ov(input logic pc, ir, mw, rw, input logic [2:0] alu, input logic a,
                                       input logic [1:0] b, input logic e, input logic [1:0] rd, m, ps,
                                       input logic d);
        return {pc, ir, mw, rw, alu, a, b, e, rd, m, ps, d};
    endfunction

    function automatic exp_t mk(input logic [3:0] st, input logic [17:0] o, input logic br = 1'b0);
        exp_t e;
        e.st = st;
        e.o = o;
        e.br = br;
        return e;
    endfunction

    function automatic logic known_op(input logic [5:0] op);
        return op inside {6'd0, 6'd2, 6'd3, 6'd4, 6'd13, 6'd15, 6'd35, 6'd43};
    endfunction

    task automatic build(input int k);
        logic [5:0] r;
        r = 6'($urandom);
        case (k)
            0: begin opcode = 6'b000000; funct = 6'b100000; end
            1: begin opcode = 6'b000000; funct = 6'b100010; end
            2: begin opcode = 6'b000000; funct = 6'b001000; end
            3: begin opcode = 6'b000000; funct = 6'b000000; end
            4: begin opcode = 6'b000000; funct = (r inside {6'b100000, 6'b100010, 6'b001000}) ? 6'b100101 : r; end
            5: begin opcode = 6'b001101; funct = r; end
            6: begin opcode = 6'b001111; funct = r; end
            7: begin opcode = 6'b100011; funct = r; end
            8: begin opcode = 6'b101011; funct = r; end
            9: begin opcode = 6'b000100; funct = r; end
            10: begin opcode = 6'b000010; funct = r; end
            11: begin opcode = 6'b000011; funct = r; end
            default: begin opcode = known_op(r) ? 6'b111111 : r; funct = 6'($urandom); end
        endcase
        q.push_back(mk(S_FETCH, ov(1, 1, 0, 0, 3'b001, 0, 2'b01, 0, 2'b00, 2'b00, 2'b00, 0)));
        q.push_back(mk(S_DECODE, ov(0, 0, 0, 0, 3'b001, 0, 2'b11, 1, 2'b00, 2'b00, 2'b00, k inside {3, 4, 12})));
        case (k)
            0, 1: begin
                q.push_back(mk(S_EXE_R, ov(0, 0, 0, 0, 3'b000, 1, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0)));
                q.push_back(mk(S_WB_R, ov(0, 0, 0, 1, 3'b001, 0, 2'b00, 0, 2'b01, 2'b00, 2'b00, 1)));
            end
            2: q.push_back(mk(S_JR, ov(1, 0, 0, 0, 3'b001, 0, 2'b00, 0, 2'b00, 2'b00, 2'b11, 1)));
            5, 6: begin
                q.push_back(mk(S_EXE_I, ov(0, 0, 0, 0, k == 6 ? 3'b100 : 3'b011, 1, 2'b10, 0, 2'b00, 2'b00, 2'b00, 0)));
                q.push_back(mk(S_WB_I, ov(0, 0, 0, 1, 3'b001, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 1)));
            end
            7: begin
                q.push_back(mk(S_MEM_ADR, ov(0, 0, 0, 0, 3'b001, 1, 2'b10, 1, 2'b00, 2'b00, 2'b00, 0)));
                q.push_back(mk(S_MEM_RD, ov(0, 0, 0, 0, 3'b001, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0)));
                q.push_back(mk(S_WB_MEM, ov(0, 0, 0, 1, 3'b001, 0, 2'b00, 0, 2'b00, 2'b01, 2'b00, 1)));
            end
            8: begin
                q.push_back(mk(S_MEM_ADR, ov(0, 0, 0, 0, 3'b001, 1, 2'b10, 1, 2'b00, 2'b00, 2'b00, 0)));
                q.push_back(mk(S_MEM_WR, ov(0, 0, 1, 0, 3'b001, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 1)));
            end
            9: q.push_back(mk(S_BRANCH, ov(0, 0, 0, 0, 3'b010, 1, 2'b00, 0, 2'b00, 2'b00, 2'b01, 1), 1'b1));
            10: q.push_back(mk(S_JUMP, ov(1, 0, 0, 0, 3'b001, 0, 2'b00, 0, 2'b00, 2'b00, 2'b10, 1)));
            11: q.push_back(mk(S_JAL, ov(1, 0, 0, 1, 3'b001, 0, 2'b00, 0, 2'b10, 2'b10, 2'b10, 1)));
            default: ;
        endcase
    endtask

    task automatic cmp(input string nm, input logic [3:0] est, input logic [17:0] eo);
        logic [17:0] act;
        act = {pc_we, ir_we, mem_we, rf_we, ALU_op, alusrc_a, alusrc_b, ext_op, reg_dst, mem_to_reg, pc_src, instr_done};
        checks++;
        if (act !== eo) begin
            errors++;
            $display("FAIL %s outputs: got %b expected %b (pc ir mw rw alu a b e rd m2r ps done) at %0t", nm, act, eo, $time);
        end
        checks++;
        if (dbg_state !== est) begin
            errors++;
            $display("FAIL %s dbg_state: got %0d expected %0d at %0t", nm, dbg_state, est, $time);
        end
    endtask

    initial begin
        logic [17:0] rst_vec, eo;
        exp_t e;
        int k, cur, zf;
        logic do_rst;
        rst_vec = ov(0, 0, 0, 0, 3'b001, 0, 2'b01, 0, 2'b00, 2'b00, 2'b00, 0);
        cur = -1;
        k = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            reset = 1'b1;
            opcode = 6'($urandom);
            funct = 6'($urandom);
            #1;
            cmp("reset_hold", S_FETCH, rst_vec);
        end
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (q.size() == 0) begin
                cur++;
                k = cur < 9 ? dir[cur] : int'($urandom_range(0, 12));
                build(k);
                if (cur < 9) begin
                    checks++;
                    if (q.size() != lat[k]) begin
                        errors++;
                        $display("FAIL latency_%s: model %0d cycles required %0d", names[k], q.size(), lat[k]);
                    end
                end
            end
            zf = cur == 3 ? 1 : cur == 4 ? 0 : int'($urandom_range(0, 1));
            zero = zf[0];
            do_rst = (cur == 8 && q[0].st == S_MEM_RD) || (cur > 8 && $urandom_range(0, 39) == 0);
            reset = do_rst;
            #1;
            e = q.pop_front();
            if (do_rst) begin
                cmp({"reset_in_", names[k]}, e.st, rst_vec);
                q.delete();
            end else begin
                eo = e.o;
                if (e.br) eo[17] = zero;
                cmp(names[k], e.st, eo);
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
